wb_stage_retire_buf: RTL and testbench

//  Parametrised writeback/retire stage for the custom RISC-V CPU: sits after MEM, holds one

---
 rtl/wb_stage_retire_buf_pkg.sv | 30 +++
 rtl/wb_stage_retire_buf_retire_fifo.sv | 59 +++++
 rtl/wb_stage_retire_buf.sv | 115 +++++++++++
 tb/tb_wb_stage_retire_buf.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_retire_buf_pkg.sv
// Shared definitions for the writeback/retire stage: retire record layout and trace policies.
package wb_stage_retire_buf_pkg;

    localparam bit TRACE_POLICY_STALL = 1'b1;
    localparam bit TRACE_POLICY_DROP  = 1'b0;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Record layout, LSB first: pc, wdata, waddr, wen.
    function automatic int retire_w(input int xlen, input int raddr_w);
        return 1 + raddr_w + 2 * xlen;
    endfunction

    function automatic int rec_pc_lsb();
        return 0;
    endfunction

    function automatic int rec_wdata_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int rec_waddr_lsb(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int rec_wen_bit(input int xlen, input int raddr_w);
        return 2 * xlen + raddr_w;
    endfunction

endpackage

// File: rtl/wb_stage_retire_buf_retire_fifo.sv
// Synchronous trace FIFO with count-based full/empty and same-cycle push/pop at any fill.
module wb_stage_retire_buf_retire_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             push_en;
    logic             pop_en;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign pop_en   = pop & !empty;
    // A pop in the same cycle frees the slot the push lands in, so full does not block it.
    assign push_en  = push & (!full | pop_en);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage_retire_buf.sv
// Writeback/retire stage: holds one completed instruction, writes the register file and
// pushes a retire record into the trace FIFO, stalling or dropping when the FIFO is full.
module wb_stage_retire_buf
    import wb_stage_retire_buf_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter bit TRACE_STALL = TRACE_POLICY_STALL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [RADDR_W-1:0]          in_waddr,
    input  logic [XLEN-1:0]             in_wdata,
    output logic                        RF_wen,
    output logic [RADDR_W-1:0]          RF_waddr,
    output logic [XLEN-1:0]             RF_wdata,
    output logic                        fwd_valid,
    output logic [RADDR_W-1:0]          fwd_addr,
    output logic [XLEN-1:0]             fwd_data,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [1+RADDR_W+2*XLEN-1:0] trace_data,
    output logic [31:0]                 retire_cnt,
    output logic [15:0]                 drop_cnt
);

    localparam int RW        = retire_w(XLEN, RADDR_W);
    localparam int PC_LSB    = rec_pc_lsb();
    localparam int WDATA_LSB = rec_wdata_lsb(XLEN);
    localparam int WADDR_LSB = rec_waddr_lsb(XLEN);
    localparam int WEN_BIT   = rec_wen_bit(XLEN, RADDR_W);

    logic               held_valid;
    logic [XLEN-1:0]    held_pc;
    logic [RADDR_W-1:0] held_waddr;
    logic [XLEN-1:0]    held_wdata;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push_ok;
    logic          retire;
    logic          push;
    logic          accept;
    logic [RW-1:0] record;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high; valid
    // never depends on ready, and in_ready depends only on held state and trace_ready.
    assign trace_valid = !fifo_empty;
    assign push_ok     = !fifo_full | (trace_valid & trace_ready);
    // Reset discards the held entry in the same cycle, so it must not retire.
    assign retire      = held_valid & !rst & (push_ok | (TRACE_STALL == TRACE_POLICY_DROP));
    assign push        = retire & push_ok;
    assign in_ready    = !held_valid | retire;
    assign accept      = in_valid & in_ready;

    assign RF_wen    = retire & (|held_waddr);
    assign RF_waddr  = held_waddr;
    assign RF_wdata  = held_wdata;
    assign fwd_valid = held_valid & (|held_waddr);
    assign fwd_addr  = held_waddr;
    assign fwd_data  = held_wdata;

    always_comb begin
        record = '0;
        record[PC_LSB    +: XLEN]    = held_pc;
        record[WDATA_LSB +: XLEN]    = held_wdata;
        record[WADDR_LSB +: RADDR_W] = held_waddr;
        record[WEN_BIT]              = RF_wen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_pc    <= '0;
            held_waddr <= '0;
            held_wdata <= '0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (in_ready) begin
                held_valid <= in_valid;
            end
            if (accept) begin
                held_pc    <= in_pc;
                held_waddr <= in_waddr;
                held_wdata <= in_wdata;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (retire && !push_ok && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    wb_stage_retire_buf_retire_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (record),
        .pop       (trace_ready),
        .pop_data  (trace_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_wb_stage_retire_buf.sv
// Directed bench for wb_stage_retire_buf: one stall-policy and one drop-policy instance.
module tb_wb_stage_retire_buf;
    import wb_stage_retire_buf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Stall-policy instance
    logic        s_in_valid = 0, s_in_ready, s_trace_ready = 0;
    logic [31:0] s_in_pc = 0, s_in_wdata = 0;
    logic [4:0]  s_in_waddr = 0;
    logic        s_rf_wen, s_fwd_valid, s_trace_valid;
    logic [4:0]  s_rf_waddr, s_fwd_addr;
    logic [31:0] s_rf_wdata, s_fwd_data, s_retire_cnt;
    logic [69:0] s_trace_data;
    logic [15:0] s_drop_cnt;

    // Drop-policy instance
    logic        d_in_valid = 0, d_in_ready, d_trace_ready = 0;
    logic [31:0] d_in_pc = 0, d_in_wdata = 0;
    logic [4:0]  d_in_waddr = 0;
    logic        d_rf_wen, d_fwd_valid, d_trace_valid;
    logic [4:0]  d_rf_waddr, d_fwd_addr;
    logic [31:0] d_rf_wdata, d_fwd_data, d_retire_cnt;
    logic [69:0] d_trace_data;
    logic [15:0] d_drop_cnt;

    wb_stage_retire_buf #(.XLEN(32), .RADDR_W(5), .FIFO_DEPTH(4), .TRACE_STALL(TRACE_POLICY_STALL)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc),
        .in_waddr(s_in_waddr), .in_wdata(s_in_wdata), .RF_wen(s_rf_wen), .RF_waddr(s_rf_waddr),
        .RF_wdata(s_rf_wdata), .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
        .trace_valid(s_trace_valid), .trace_ready(s_trace_ready), .trace_data(s_trace_data),
        .retire_cnt(s_retire_cnt), .drop_cnt(s_drop_cnt)
    );

    wb_stage_retire_buf #(.XLEN(32), .RADDR_W(5), .FIFO_DEPTH(4), .TRACE_STALL(TRACE_POLICY_DROP)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_pc(d_in_pc),
        .in_waddr(d_in_waddr), .in_wdata(d_in_wdata), .RF_wen(d_rf_wen), .RF_waddr(d_rf_waddr),
        .RF_wdata(d_rf_wdata), .fwd_valid(d_fwd_valid), .fwd_addr(d_fwd_addr), .fwd_data(d_fwd_data),
        .trace_valid(d_trace_valid), .trace_ready(d_trace_ready), .trace_data(d_trace_data),
        .retire_cnt(d_retire_cnt), .drop_cnt(d_drop_cnt)
    );

    // Expected record layout {wen, waddr, wdata, pc}
    function automatic logic [69:0] rec(input logic wen, input logic [4:0] wa,
                                        input logic [31:0] wd, input logic [31:0] pc);
        return {wen, wa, wd, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_in_valid = 0; s_trace_ready = 0;
        d_in_valid = 0; d_trace_ready = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Instruction k: pc = base + 4k, waddr = k + 1, wdata = pc + 4
    task automatic drive_s(input logic v, input logic [31:0] base, input int k);
        s_in_valid = v;
        s_in_pc    = base + 32'(4 * k);
        s_in_waddr = 5'(k + 1);
        s_in_wdata = base + 32'(4 * k) + 32'd4;
    endtask

    task automatic drive_d(input logic v, input logic [31:0] base, input int k);
        d_in_valid = v;
        d_in_pc    = base + 32'(4 * k);
        d_in_waddr = 5'(k + 1);
        d_in_wdata = base + 32'(4 * k) + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_in_valid = 1'b1;
        d_in_valid = 1'b1;
        tick();
        tick();
        checks++; if (s_rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen got=%b exp=0", s_rf_wen); end
        checks++; if (s_trace_valid !== 1'b0) begin failures++; $display("FAIL reset_trace_valid got=%b exp=0", s_trace_valid); end
        checks++; if (s_retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_retire_cnt got=%0d exp=0", s_retire_cnt); end
        checks++; if (s_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", s_drop_cnt); end
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
        checks++; if (d_retire_cnt !== 32'd0 || d_drop_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_drop_inst_counts got=%0d/%0d exp=0/0", d_retire_cnt, d_drop_cnt);
        end
        rst = 1'b0;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] base;
        base = 32'h200;
        do_reset();
        s_trace_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_s(c < 8, base, c);
            #1;
            if (c < 8) begin
                checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, s_in_ready); end
            end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (s_rf_wen !== 1'b1 || s_rf_waddr !== 5'(c) || s_rf_wdata !== base + 32'(4 * (c - 1)) + 32'd4) begin
                    failures++; $display("FAIL stream_rf c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, s_rf_wen, s_rf_waddr,
                                         s_rf_wdata, c, base + 32'(4 * (c - 1)) + 32'd4);
                end
            end
            if (c >= 2) begin
                checks++;
                if (s_trace_valid !== 1'b1 ||
                    s_trace_data !== rec(1'b1, 5'(c - 1), base + 32'(4 * (c - 2)) + 32'd4, base + 32'(4 * (c - 2)))) begin
                    failures++; $display("FAIL stream_trace c=%0d got=%b/%h", c, s_trace_valid, s_trace_data);
                end
            end
            if (c == 9) begin
                checks++; if (s_retire_cnt !== 32'd8) begin failures++; $display("FAIL stream_retire_cnt got=%0d exp=8", s_retire_cnt); end
                checks++; if (s_rf_wen !== 1'b0) begin failures++; $display("FAIL stream_idle_rf_wen got=%b exp=0", s_rf_wen); end
            end
            tick();
        end
        s_trace_ready = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic test_waddr_zero();
        do_reset();
        s_in_valid = 1'b1; s_in_pc = 32'h100; s_in_waddr = 5'd0; s_in_wdata = 32'hABCD;
        tick();
        s_in_valid = 1'b0;
        #1;
        checks++; if (s_rf_wen !== 1'b0) begin failures++; $display("FAIL x0_rf_wen got=%b exp=0", s_rf_wen); end
        checks++; if (s_fwd_valid !== 1'b0) begin failures++; $display("FAIL x0_fwd_valid got=%b exp=0", s_fwd_valid); end
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL x0_in_ready got=%b exp=1", s_in_ready); end
        tick();
        checks++;
        if (s_trace_valid !== 1'b1 || s_trace_data !== rec(1'b0, 5'd0, 32'hABCD, 32'h100)) begin
            failures++; $display("FAIL x0_record got=%b/%h exp=1/%h", s_trace_valid, s_trace_data, rec(1'b0, 5'd0, 32'hABCD, 32'h100));
        end
        checks++; if (s_retire_cnt !== 32'd1) begin failures++; $display("FAIL x0_retire_cnt got=%0d exp=1", s_retire_cnt); end
    endtask

    task automatic test_stall();
        logic [31:0] base;
        base = 32'h300;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_s(1'b1, base, c);
            #1;
            checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_in_ready c=%0d got=%b exp=1", c, s_in_ready); end
            if (c >= 1) begin
                checks++; if (s_rf_wen !== 1'b1) begin failures++; $display("FAIL stall_fill_rf_wen c=%0d got=%b exp=1", c, s_rf_wen); end
            end
            tick();
        end
        drive_s(1'b1, base, 5);
        for (int c = 5; c < 7; c++) begin
            #1;
            checks++;
            if (s_rf_wen !== 1'b0 || s_in_ready !== 1'b0) begin
                failures++; $display("FAIL stall_blocked c=%0d got=%b/%b exp=0/0", c, s_rf_wen, s_in_ready);
            end
            checks++;
            if (s_fwd_valid !== 1'b1 || s_fwd_addr !== 5'd5 || s_fwd_data !== base + 32'd20) begin
                failures++; $display("FAIL stall_held c=%0d got=%b/%0d/%h exp=1/5/%h", c, s_fwd_valid, s_fwd_addr, s_fwd_data, base + 32'd20);
            end
            checks++; if (s_retire_cnt !== 32'd4) begin failures++; $display("FAIL stall_retire_cnt c=%0d got=%0d exp=4", c, s_retire_cnt); end
            checks++;
            if (s_trace_data !== rec(1'b1, 5'd1, base + 32'd4, base)) begin
                failures++; $display("FAIL stall_head_stable c=%0d got=%h", c, s_trace_data);
            end
            tick();
        end
        s_trace_ready = 1'b1;
        #1;
        checks++;
        if (s_rf_wen !== 1'b1 || s_rf_waddr !== 5'd5 || s_in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_release got=%b/%0d/%b exp=1/5/1", s_rf_wen, s_rf_waddr, s_in_ready);
        end
        tick();
        s_trace_ready = 1'b0;
        s_in_valid = 1'b0;
        #1;
        checks++;
        if (s_rf_wen !== 1'b0 || s_in_ready !== 1'b0 || s_retire_cnt !== 32'd5) begin
            failures++; $display("FAIL stall_after_one got=%b/%b/%0d exp=0/0/5", s_rf_wen, s_in_ready, s_retire_cnt);
        end
        checks++;
        if (s_trace_data !== rec(1'b1, 5'd2, base + 32'd8, base + 32'd4) || s_fwd_addr !== 5'd6) begin
            failures++; $display("FAIL stall_after_one_state got=%h/%0d exp_addr=6", s_trace_data, s_fwd_addr);
        end
    endtask

    task automatic test_drop();
        logic [31:0] base;
        base = 32'h400;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive_d(c < 6, base, c);
            #1;
            checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL drop_in_ready c=%0d got=%b exp=1", c, d_in_ready); end
            if (c >= 1) begin
                checks++; if (d_rf_wen !== 1'b1) begin failures++; $display("FAIL drop_rf_wen c=%0d got=%b exp=1", c, d_rf_wen); end
            end
            tick();
        end
        d_in_valid = 1'b0;
        checks++; if (d_retire_cnt !== 32'd6) begin failures++; $display("FAIL drop_retire_cnt got=%0d exp=6", d_retire_cnt); end
        checks++; if (d_drop_cnt !== 16'd2) begin failures++; $display("FAIL drop_drop_cnt got=%0d exp=2", d_drop_cnt); end
        d_trace_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (d_trace_valid !== 1'b1 || d_trace_data !== rec(1'b1, 5'(j + 1), base + 32'(4 * j) + 32'd4, base + 32'(4 * j))) begin
                failures++; $display("FAIL drop_fifo_order j=%0d got=%b/%h", j, d_trace_valid, d_trace_data);
            end
            tick();
        end
        checks++; if (d_trace_valid !== 1'b0) begin failures++; $display("FAIL drop_fifo_drained got=%b exp=0", d_trace_valid); end
        d_trace_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        base = 32'h500;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_s(1'b1, base, c);
            tick();
        end
        s_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (s_rf_wen !== 1'b0) begin failures++; $display("FAIL midrst_rf_wen got=%b exp=0", s_rf_wen); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (s_trace_valid !== 1'b0) begin failures++; $display("FAIL midrst_trace_valid got=%b exp=0", s_trace_valid); end
        checks++; if (s_retire_cnt !== 32'd0) begin failures++; $display("FAIL midrst_retire_cnt got=%0d exp=0", s_retire_cnt); end
        checks++;
        if (s_fwd_valid !== 1'b0 || s_in_ready !== 1'b1 || s_rf_wen !== 1'b0) begin
            failures++; $display("FAIL midrst_held got=%b/%b/%b exp=0/1/0", s_fwd_valid, s_in_ready, s_rf_wen);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_waddr_zero();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
